ram_port_arbiter: RTL and testbench
===================================

// Module: ram_port_arbiter
// PURPOSE
//  Shares the CPU's single-port block RAM between two requesters:
//  - instruction fetch (F): read-only
//  - load/store unit (M): read or write
//  Sits between the CPU core and the RAM. Sequences every access as issue -> read-latency wait -> acknowledge.
//  Grants the RAM round-robin when both requesters ask in the same cycle.
// PARAMETERS
//  ADDR_W  16  address width, bits
//  DATA_W  16  data width, bits
//  RD_LAT  1   RAM read latency in cycles, counted from the ram_en edge to valid ram_rdata; legal range 1..3
// PORTS
//  clka       in   1       single clock; all logic on rising edge
//  rst        in   1       asynchronous, active-low reset (0 = reset)
//  f_req      in   1       fetch request; held until f_ack
//  f_addr     in   ADDR_W  fetch address
//  f_ack      out  1       1-cycle pulse: fetch done, rdata valid
//  m_req      in   1       load/store request; held until m_ack
//  m_we       in   1       1 = write, 0 = read
//  m_addr     in   ADDR_W  load/store address
//  m_wdata    in   DATA_W  write data
//  m_ack      out  1       1-cycle pulse: load/store done (rdata valid if read)
//  rdata      out  DATA_W  read data; valid only in the ack cycle; holds its value otherwise
//  ram_en     out  1       RAM enable
//  ram_we     out  1       RAM write enable
//  ram_addr   out  ADDR_W  RAM address
//  ram_wdata  out  DATA_W  RAM write data
//  ram_rdata  in   DATA_W  RAM read data
//  busy       out  1       1 whenever state != IDLE
// BEHAVIOUR
//  - All outputs are registered.
//  - While rst=0, immediately and independent of clka:
//    - state=IDLE
//    - f_ack, m_ack, ram_en, ram_we, busy = 0
//    - ram_addr, ram_wdata, rdata = 0
//    - last_grant=M, so F wins the first contention
//  - FSM states: IDLE -> ISSUE -> [WAIT x RD_LAT, reads only] -> DONE -> IDLE.
//  - IDLE: samples f_req and m_req.
//    - Neither set: stay in IDLE.
//    - One set: grant that requester.
//    - Both set: grant the requester that is not last_grant.
//    - On grant, latch addr, we and wdata; set last_grant to the winner; go to ISSUE.
//    - F is always we=0.
//  - ISSUE (1 cycle):
//    - ram_en=1; ram_we=latched we; ram_addr and ram_wdata = latched values.
//    - Next state: write -> DONE; read -> WAIT with counter=RD_LAT.
//  - WAIT:
//    - ram_en=0; counter decrements each cycle.
//    - In the last WAIT cycle, rdata <= ram_rdata; then go to DONE.
//  - DONE (1 cycle): ack of the granted port = 1; go to IDLE.
//  - The ungranted port's ack is never asserted.
//  - Latency, with req sampled in IDLE at cycle 0:
//    - write: ram_en in cycle 1, ack in cycle 2
//    - read: ram_en in cycle 1, ack in cycle 2+RD_LAT
//  - Handshake:
//    - A requester drops req, or presents a new request, in the cycle after ack.
//    - IDLE in that cycle samples the new req, so back-to-back reads have a period of 3+RD_LAT cycles.
//  - Changes to addr, we or wdata after grant are ignored until the next grant.
//  - A req deasserted before grant is simply not served; no error.
//  - Fairness: under continuous contention, grants strictly alternate F, M, F, M.
//    No requester waits more than one other transaction.
//  - Reset mid-operation: any in-flight access is abandoned and no ack is issued.
//    After rst returns to 1, the FSM restarts in IDLE.
// TESTING
//  1. RD_LAT=1, f_req=1, f_addr=0x0010, RAM returns 0xBEEF
//     -> ram_en=1, ram_we=0, ram_addr=0x0010 in cycle 1
//     -> f_ack pulse in cycle 3 with rdata=0xBEEF; m_ack stays 0
//  2. m_req=1, m_we=1, m_addr=0x0020, m_wdata=0x1234
//     -> ram_en=ram_we=1, ram_addr=0x0020, ram_wdata=0x1234 in cycle 1
//     -> m_ack in cycle 2; rdata unchanged
//  3. f_req and m_req held at 1 from reset release, 4 transactions
//     -> grant order F, M, F, M
//     -> acks at cycles 3, 7, 11, 15 (RD_LAT=1, all reads)
//  4. M issues back-to-back reads 0x0030 then 0x0031
//     -> second ram_en exactly 2 cycles after the first m_ack
//     -> two distinct acks with the correct rdata
//  5. rst=0 during WAIT of a read
//     -> ram_en, acks and busy are 0 immediately; no ack is emitted
//     -> after release, contention grants F first
//  6. RD_LAT=3, fetch read of 0x0040 returning 0x5A5A
//     -> f_ack in cycle 5 with rdata=0x5A5A
//     -> busy=1 in cycles 1..5

Source files
------------

// File: rtl/ram_port_arbiter_if.sv
// rtl/ram_port_arbiter_if.sv - requester and RAM signal bundle for the RAM port arbiter
interface ram_port_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              f_req;
    logic [ADDR_W-1:0] f_addr;
    logic              f_ack;
    logic              m_req;
    logic              m_we;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic              m_ack;
    logic [DATA_W-1:0] rdata;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              busy;

    // Arbiter side
    modport slave (
        input  f_req, f_addr, m_req, m_we, m_addr, m_wdata, ram_rdata,
        output f_ack, m_ack, rdata, ram_en, ram_we, ram_addr, ram_wdata, busy
    );

    // Core and RAM side
    modport master (
        output f_req, f_addr, m_req, m_we, m_addr, m_wdata, ram_rdata,
        input  f_ack, m_ack, rdata, ram_en, ram_we, ram_addr, ram_wdata, busy
    );
endinterface

// File: rtl/ram_port_arbiter.sv
// rtl/ram_port_arbiter.sv - round-robin sharing of one single-port RAM between fetch and load/store
module ram_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int RD_LAT = 1
) (
    input  logic              clka,
    input  logic              rst,
    ram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

    localparam logic GRANT_F = 1'b0;
    localparam logic GRANT_M = 1'b1;

    state_e            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              last_grant_q, last_grant_d;
    logic              grant_q, grant_d;
    logic              we_q, we_d;
    logic              f_ack_q, f_ack_d;
    logic              m_ack_q, m_ack_d;
    logic              ram_en_q, ram_en_d;
    logic              ram_we_q, ram_we_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              pick_m;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        we_d         = we_q;
        f_ack_d      = 1'b0;
        m_ack_d      = 1'b0;
        ram_en_d     = 1'b0;
        ram_we_d     = 1'b0;
        ram_addr_d   = ram_addr_q;
        ram_wdata_d  = ram_wdata_q;
        rdata_d      = rdata_q;
        pick_m       = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.f_req || bus.m_req) begin
                    // On contention the port that did not win last time goes next
                    pick_m       = bus.m_req && (!bus.f_req || last_grant_q == GRANT_F);
                    grant_d      = pick_m;
                    last_grant_d = pick_m;
                    we_d         = pick_m && bus.m_we;
                    ram_addr_d   = pick_m ? bus.m_addr : bus.f_addr;
                    if (pick_m) begin
                        ram_wdata_d = bus.m_wdata;
                    end
                    ram_en_d     = 1'b1;
                    ram_we_d     = pick_m && bus.m_we;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                if (we_q) begin
                    state_d = DONE;
                    f_ack_d = (grant_q == GRANT_F);
                    m_ack_d = (grant_q == GRANT_M);
                end else begin
                    state_d = WAIT;
                    cnt_d   = 2'(RD_LAT);
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd1) begin
                    rdata_d = bus.ram_rdata;
                    state_d = DONE;
                    f_ack_d = (grant_q == GRANT_F);
                    m_ack_d = (grant_q == GRANT_M);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            cnt_q        <= 2'd0;
            last_grant_q <= GRANT_M;
            grant_q      <= GRANT_F;
            we_q         <= 1'b0;
            f_ack_q      <= 1'b0;
            m_ack_q      <= 1'b0;
            ram_en_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            ram_addr_q   <= '0;
            ram_wdata_q  <= '0;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            we_q         <= we_d;
            f_ack_q      <= f_ack_d;
            m_ack_q      <= m_ack_d;
            ram_en_q     <= ram_en_d;
            ram_we_q     <= ram_we_d;
            ram_addr_q   <= ram_addr_d;
            ram_wdata_q  <= ram_wdata_d;
            rdata_q      <= rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.f_ack     = f_ack_q;
    assign bus.m_ack     = m_ack_q;
    assign bus.ram_en    = ram_en_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_ram_port_arbiter.sv
// tb/tb_ram_port_arbiter.sv - randomized transaction-level check of ram_port_arbiter at RD_LAT 1 and 3
module tb_ram_port_arbiter;
    localparam int AW = 16;
    localparam int DW = 16;
    localparam int N  = 2;

    typedef enum int {M_CONT, M_RAND, M_B2B} mode_e;
    typedef struct { int c; int p; } ack_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]         f_req   = '0;
    logic [N-1:0]         m_req   = '0;
    logic [N-1:0]         m_we    = '0;
    logic [N-1:0][AW-1:0] f_addr  = '0;
    logic [N-1:0][AW-1:0] m_addr  = '0;
    logic [N-1:0][DW-1:0] m_wdata = '0;
    logic [N-1:0]         f_ack, m_ack, ram_en, ram_we, busy;
    logic [N-1:0][AW-1:0] ram_addr;
    logic [N-1:0][DW-1:0] ram_wdata, rdata;

    mode_e mode = M_CONT;
    int    cyc = 0;
    int    n_checks = 0;
    int    n_errors = 0;
    ack_t  ack_log[$];
    logic [N-1:0][AW-1:0] b2b_addr = {16'h0030, 16'h0030};

    // Transaction-level reference: one window [iss, ack] per granted access
    int               iss [N];
    int               ack [N];
    int               win [N];
    int               last [N];
    bit               mwe [N];
    logic [AW-1:0]    maddr [N];
    logic [DW-1:0]    mwdata [N];
    logic [DW-1:0]    ack_data [N];
    logic [DW-1:0]    exp_rdata [N];
    logic [DW-1:0]    shadow [N][256];
    bit               sh_done = 1'b0;

    function automatic int lat(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic logic [DW-1:0] init_word(input int a);
        return DW'((a * 257) ^ 32'h3C5A);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    for (genvar g = 0; g < N; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : 3;
        ram_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
        logic [DW-1:0] mem [256];
        logic [DW-1:0] pipe [L];
        bit            inited = 1'b0;

        assign bus.f_req     = f_req[g];
        assign bus.f_addr    = f_addr[g];
        assign bus.m_req     = m_req[g];
        assign bus.m_we      = m_we[g];
        assign bus.m_addr    = m_addr[g];
        assign bus.m_wdata   = m_wdata[g];
        assign bus.ram_rdata = pipe[L-1];
        assign f_ack[g]      = bus.f_ack;
        assign m_ack[g]      = bus.m_ack;
        assign ram_en[g]     = bus.ram_en;
        assign ram_we[g]     = bus.ram_we;
        assign ram_addr[g]   = bus.ram_addr;
        assign ram_wdata[g]  = bus.ram_wdata;
        assign rdata[g]      = bus.rdata;
        assign busy[g]       = bus.busy;

        ram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(L)) u_dut (
            .clka (clk),
            .rst  (rst_n),
            .bus  (bus.slave)
        );

        // RAM with L-cycle read pipeline; garbage flows through when not reading
        always @(posedge clk) begin
            if (!inited) begin
                for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
                inited <= 1'b1;
            end else if (bus.ram_en && bus.ram_we) begin
                mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
            end
            pipe[0] <= (bus.ram_en && !bus.ram_we) ? mem[bus.ram_addr[7:0]] : DW'($urandom);
            for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
        end
    end

    always @(posedge clk) begin
        for (int g = 0; g < N; g++) begin
            if (!rst_n) begin
                iss[g]  = -1;
                ack[g]  = -1;
                win[g]  = 0;
                last[g] = 1;
                mwe[g]  = 1'b0;
                if (!sh_done) for (int a = 0; a < 256; a++) shadow[g][a] = init_word(a);
            end else if (cyc > ack[g] && (f_req[g] || m_req[g])) begin
                win[g]    = (f_req[g] && m_req[g]) ? 1 - last[g] : (m_req[g] ? 1 : 0);
                last[g]   = win[g];
                mwe[g]    = (win[g] == 1) && m_we[g];
                maddr[g]  = (win[g] == 1) ? m_addr[g] : f_addr[g];
                mwdata[g] = m_wdata[g];
                iss[g]    = cyc + 1;
                ack[g]    = cyc + 2 + (mwe[g] ? 0 : lat(g));
                if (mwe[g]) shadow[g][maddr[g][7:0]] = mwdata[g];
                else        ack_data[g] = shadow[g][maddr[g][7:0]];
            end
        end
        if (!rst_n) sh_done = 1'b1;
        cyc++;
    end

    task automatic set_req(input int g, input int p, input logic v);
        if (p == 0) f_req[g] = v;
        else        m_req[g] = v;
    endtask

    task automatic start_req(input int g, input int p);
        set_req(g, p, 1'b1);
        if (p == 0) begin
            f_addr[g] = AW'($urandom);
        end else begin
            m_wdata[g] = DW'($urandom);
            if (mode == M_B2B) begin
                m_addr[g]   = b2b_addr[g];
                b2b_addr[g] = b2b_addr[g] + 16'd1;
                m_we[g]     = 1'b0;
            end else begin
                m_addr[g] = AW'($urandom);
                m_we[g]   = (mode == M_RAND) ? 1'($urandom_range(1)) : 1'b0;
            end
        end
    endtask

    task automatic drive(input int g, input int c);
        for (int p = 0; p < 2; p++) begin
            logic req;
            bit   inf, done;
            req  = (p == 0) ? f_req[g] : m_req[g];
            inf  = rst_n && win[g] == p && c >= iss[g] && c <= ack[g];
            done = inf && c == ack[g];
            if (done) begin
                set_req(g, p, 1'b0);
                if (mode == M_CONT || (mode == M_B2B && p == 1) ||
                    (mode == M_RAND && $urandom_range(1) == 1)) start_req(g, p);
            end else if (req && !inf) begin
                if ((mode == M_RAND && $urandom_range(15) == 0) || (mode == M_B2B && p == 0))
                    set_req(g, p, 1'b0);
            end else if (req && inf) begin
                // Post-grant changes must be ignored by the arbiter
                if (mode == M_RAND && $urandom_range(1) == 1) begin
                    if (p == 0) f_addr[g] = AW'($urandom);
                    else begin
                        m_addr[g]  = AW'($urandom);
                        m_wdata[g] = DW'($urandom);
                        m_we[g]    = 1'($urandom_range(1));
                    end
                end
            end else if (!req) begin
                if (mode == M_CONT || (mode == M_B2B && p == 1) ||
                    (mode == M_RAND && $urandom_range(2) == 0)) start_req(g, p);
            end
        end
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < N; g++) begin
            int c;
            bit en_e;
            c = cyc;
            if (!rst_n) begin
                exp_rdata[g] = '0;
                check($sformatf("i%0d_rst_busy", g),     32'(busy[g]),     32'd0);
                check($sformatf("i%0d_rst_ram_en", g),   32'(ram_en[g]),   32'd0);
                check($sformatf("i%0d_rst_ram_we", g),   32'(ram_we[g]),   32'd0);
                check($sformatf("i%0d_rst_f_ack", g),    32'(f_ack[g]),    32'd0);
                check($sformatf("i%0d_rst_m_ack", g),    32'(m_ack[g]),    32'd0);
                check($sformatf("i%0d_rst_rdata", g),    32'(rdata[g]),    32'd0);
                check($sformatf("i%0d_rst_ram_addr", g), 32'(ram_addr[g]), 32'd0);
            end else begin
                en_e = (c == iss[g]);
                check($sformatf("i%0d_ram_en", g), 32'(ram_en[g]), 32'(en_e));
                if (en_e) begin
                    check($sformatf("i%0d_ram_we", g),   32'(ram_we[g]),   32'(mwe[g]));
                    check($sformatf("i%0d_ram_addr", g), 32'(ram_addr[g]), 32'(maddr[g]));
                    if (mwe[g]) check($sformatf("i%0d_ram_wdata", g), 32'(ram_wdata[g]), 32'(mwdata[g]));
                end
                if (c == ack[g] && !mwe[g]) exp_rdata[g] = ack_data[g];
                check($sformatf("i%0d_f_ack", g), 32'(f_ack[g]), 32'(c == ack[g] && win[g] == 0));
                check($sformatf("i%0d_m_ack", g), 32'(m_ack[g]), 32'(c == ack[g] && win[g] == 1));
                check($sformatf("i%0d_busy", g),  32'(busy[g]),  32'(c >= iss[g] && c <= ack[g]));
                check($sformatf("i%0d_rdata", g), 32'(rdata[g]), 32'(exp_rdata[g]));
            end
            if (g == 0 && (f_ack[0] || m_ack[0])) ack_log.push_back('{c, int'(m_ack[0])});
            drive(g, c);
        end
    end

    initial begin
        int  base;
        int  lb;
        bit  found;

        // Continuous contention from reset release: F, M, F, M at cycles 3, 7, 11, 15
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        base  = cyc;
        repeat (20) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (ack_log.size() > k) begin
                check($sformatf("t3_ack%0d_cycle", k), 32'(ack_log[k].c - base), 32'(3 + 4 * k));
                check($sformatf("t3_ack%0d_port", k),  32'(ack_log[k].p),        32'(k % 2));
            end else begin
                check($sformatf("t3_ack%0d_seen", k), 32'd0, 32'd1);
            end
        end

        mode = M_RAND;
        repeat (1500) @(negedge clk);

        // Reset while the RD_LAT=3 instance is waiting on a read
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(posedge clk);
            #1;
            if (cyc > iss[1] && cyc < ack[1] && !mwe[1] && !(cyc == iss[0] && mwe[0])) found = 1'b1;
        end
        check("t5_wait_found", 32'(found), 32'd1);
        if (found) begin
            rst_n = 1'b0;
            mode  = M_CONT;
            #1;
            for (int g = 0; g < N; g++) begin
                check($sformatf("t5_i%0d_busy_async", g),   32'(busy[g]),   32'd0);
                check($sformatf("t5_i%0d_ram_en_async", g), 32'(ram_en[g]), 32'd0);
                check($sformatf("t5_i%0d_acks_async", g),   32'(f_ack[g] | m_ack[g]), 32'd0);
            end
            repeat (3) @(negedge clk);
            rst_n = 1'b1;
            base  = cyc;
            lb    = ack_log.size();
            repeat (8) @(negedge clk);
            if (ack_log.size() > lb) begin
                check("t5_first_ack_cycle", 32'(ack_log[lb].c - base), 32'd3);
                check("t5_first_ack_port",  32'(ack_log[lb].p),        32'd0);
            end else begin
                check("t5_first_ack_seen", 32'd0, 32'd1);
            end
        end

        mode = M_B2B;
        repeat (300) @(negedge clk);
        mode = M_RAND;
        repeat (600) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
